// File: rtl/mmio_initiator.sv
// mmio_initiator: issues one MMIO read or write at a time to an AFU and
// reports a single completion per accepted command.
//
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   cmd_valid/ready     command handshake (ready only while idle)
//   cmd_wr/addr/data    command: 1 = write, 0 = read; word address; write data
//   mmio_wr_valid       one-cycle write request pulse
//   mmio_rd_valid       one-cycle read request pulse
//   mmio_addr/tid/data  request fields, held between pulses
//   rsp_valid/tid/data  AFU read response
//   done_valid          one-cycle completion pulse
//   done_data/err       completion data and status
//                       (00 ok, 01 timeout, 10 TID mismatch, 11 misaligned)
//   stray_cnt           saturating count of responses seen outside WAIT_RSP
module mmio_initiator #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_wr,
  input  logic [15:0] cmd_addr,
  input  logic [63:0] cmd_data,
  output logic        mmio_wr_valid,
  output logic        mmio_rd_valid,
  output logic [15:0] mmio_addr,
  output logic [8:0]  mmio_tid,
  output logic [63:0] mmio_data,
  input  logic        rsp_valid,
  input  logic [8:0]  rsp_tid,
  input  logic [63:0] rsp_data,
  output logic        done_valid,
  output logic [63:0] done_data,
  output logic [1:0]  done_err,
  output logic [7:0]  stray_cnt
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_RSP,
    DONE
  } state_t;

  state_t        state;
  logic          wr_q;
  logic [8:0]    tid_ctr;
  logic [CW-1:0] tmo_cnt;
  logic          tmo_hit;

  // Ready is a decode of IDLE, forced low while reset is held.
  assign cmd_ready = !rst && (state == IDLE);

  // Counter starts at 0 on entry to WAIT_RSP, so the last waiting cycle
  // is the one where it reads TIMEOUT_CYCLES-1.
  assign tmo_hit = (tmo_cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      wr_q          <= 1'b0;
      tid_ctr       <= '0;
      tmo_cnt       <= '0;
      mmio_wr_valid <= 1'b0;
      mmio_rd_valid <= 1'b0;
      mmio_addr     <= '0;
      mmio_tid      <= '0;
      mmio_data     <= '0;
      done_valid    <= 1'b0;
      done_data     <= '0;
      done_err      <= 2'b00;
      stray_cnt     <= '0;
    end else begin
      mmio_wr_valid <= 1'b0;
      mmio_rd_valid <= 1'b0;
      done_valid    <= 1'b0;

      if (rsp_valid && (state != WAIT_RSP) && (stray_cnt != 8'hFF))
        stray_cnt <= stray_cnt + 8'd1;

      case (state)
        IDLE: begin
          if (cmd_valid) begin
            wr_q <= cmd_wr;
            if (cmd_addr[0]) begin
              // Misaligned: complete without touching the AFU.
              done_valid <= 1'b1;
              done_data  <= '0;
              done_err   <= 2'b11;
              state      <= DONE;
            end else begin
              // Request pulse is registered here so it lands in the
              // cycle spent in ISSUE.
              mmio_addr <= cmd_addr;
              if (cmd_wr) begin
                mmio_data     <= cmd_data;
                mmio_wr_valid <= 1'b1;
              end else begin
                mmio_tid      <= tid_ctr;
                mmio_rd_valid <= 1'b1;
              end
              state <= ISSUE;
            end
          end
        end

        ISSUE: begin
          if (wr_q) begin
            done_valid <= 1'b1;
            done_data  <= '0;
            done_err   <= 2'b00;
            state      <= DONE;
          end else begin
            tid_ctr <= tid_ctr + 9'd1;
            tmo_cnt <= '0;
            state   <= WAIT_RSP;
          end
        end

        WAIT_RSP: begin
          if (rsp_valid) begin
            // A response takes priority over an expiring timeout.
            done_valid <= 1'b1;
            done_data  <= rsp_data;
            done_err   <= (rsp_tid == mmio_tid) ? 2'b00 : 2'b10;
            state      <= DONE;
          end else if (tmo_hit) begin
            done_valid <= 1'b1;
            done_data  <= '0;
            done_err   <= 2'b01;
            state      <= DONE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/mmio_initiator.md
MMIO_INITIATOR -- requirements
Module: mmio_initiator

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 256; cycles to wait for a read response before abort.
REQ-002 SHALL have clk, input, 1; rising-edge clock for all state.
REQ-003 SHALL have rst, input, 1; reset, asynchronous, active-high.
REQ-004 SHALL have cmd_valid, input, 1; user command request.
REQ-005 SHALL have cmd_ready, output, 1; command accepted when cmd_valid && cmd_ready.
REQ-006 SHALL have cmd_wr, input, 1; 1 = MMIO write, 0 = MMIO read.
REQ-007 SHALL have cmd_addr, input, 16; MMIO address in 32-bit word units.
REQ-008 SHALL have cmd_data, input, 64; write data.
REQ-009 SHALL have mmio_wr_valid, output, 1; single-cycle write request pulse to the AFU.
REQ-010 SHALL have mmio_rd_valid, output, 1; single-cycle read request pulse to the AFU.
REQ-011 SHALL have mmio_addr, output, 16; request address.
REQ-012 SHALL have mmio_tid, output, 9; request transaction ID.
REQ-013 SHALL have mmio_data, output, 64; request write data.
REQ-014 SHALL have rsp_valid, input, 1; AFU read-response valid.
REQ-015 SHALL have rsp_tid, input, 9; TID echoed by the AFU.
REQ-016 SHALL have rsp_data, input, 64; AFU read data.
REQ-017 SHALL have done_valid, output, 1; single-cycle completion pulse.
REQ-018 SHALL have done_data, output, 64; read data, or 0 for writes and timeouts.
REQ-019 SHALL have done_err, output, 2; 00 ok, 01 timeout, 10 TID mismatch, 11 misaligned.
REQ-020 SHALL have stray_cnt, output, 8; count of responses received while no read is outstanding; saturates at 255.

Function
REQ-021 SHALL implement states IDLE, ISSUE, WAIT_RSP, DONE; one transaction in flight at most.
REQ-022 SHALL drive cmd_ready = 1 only in IDLE.
REQ-023 On accept in cycle N, SHALL capture cmd_wr/addr/data and enter ISSUE; request pulse in cycle N+1.
REQ-024 If cmd_addr[0] = 1 on accept, SHALL issue no request, go to DONE, and report done_err = 11, done_data = 0.
REQ-025 In ISSUE, write: SHALL assert mmio_wr_valid for exactly 1 cycle, then enter DONE; done_valid asserts in N+2 with err 00.
REQ-026 In ISSUE, read: SHALL assert mmio_rd_valid for exactly 1 cycle with mmio_tid = tid_ctr, then enter WAIT_RSP and clear the timeout counter.
REQ-027 tid_ctr SHALL increment by 1 after each issued read, wrap 511 -> 0, and not change on writes.
REQ-028 mmio_addr/mmio_data/mmio_tid SHALL hold their last value outside request pulses.
REQ-029 In WAIT_RSP, on rsp_valid with rsp_tid == issued TID, SHALL capture rsp_data and go to DONE with err 00.
REQ-030 In WAIT_RSP, on rsp_valid with rsp_tid != issued TID, SHALL capture rsp_data and go to DONE with err 10.
REQ-031 In WAIT_RSP with no rsp_valid, the counter SHALL increment; at TIMEOUT_CYCLES cycles without a response SHALL go to DONE with err 01, data 0.
REQ-032 If rsp_valid arrives in the same cycle the timeout expires, the response SHALL win.
REQ-033 In DONE, SHALL pulse done_valid for 1 cycle with the captured data/err, then return to IDLE; the next command can be accepted in the following cycle.
REQ-034 Any rsp_valid in IDLE, ISSUE or DONE SHALL be ignored for completion and SHALL increment stray_cnt, saturating.
REQ-035 A late response to a timed-out read SHALL count as stray.

Reset
REQ-036 On rst, SHALL enter IDLE asynchronously, abandon any in-flight transaction without a done pulse, and clear tid_ctr, the timeout counter and stray_cnt.
REQ-037 Reset values: cmd_ready 0 while rst is high, then 1; mmio_wr_valid 0; mmio_rd_valid 0; mmio_addr 0; mmio_tid 0; mmio_data 0; done_valid 0; done_data 0; done_err 00; stray_cnt 0.

Verification
REQ-038 Write addr 0x0020, data 0xDEADBEEF_CAFEF00D -> one mmio_wr_valid pulse with those values; done_valid 2 cycles after accept, err 00, data 0.
REQ-039 Read addr 0x0000, AFU replies TID 0 with 0x1000_0000_0000_0000 three cycles later -> done_data equals that value, err 00; next read uses TID 1.
REQ-040 Read with no response (TIMEOUT_CYCLES = 16) -> done after 16 wait cycles, err 01, data 0; a later reply with the old TID increments stray_cnt to 1.
REQ-041 Read issued with TID 5, AFU replies TID 6 -> err 10, done_data = rsp_data.
REQ-042 Command addr 0x0003 -> no mmio pulse; done err 11. Also: 512 reads -> TID wraps 511 -> 0.
REQ-043 rst asserted during WAIT_RSP -> no done_valid, all outputs at reset values, next read uses TID 0.
